systolic_feed_ctrl: RTL

//  Job sequencer for the 4x4 output-stationary systolic_array.
//  - Buffers a 4x4 A matrix (rows) and a 4x4 B matrix (columns) written over a load handshake.
//  - On start: clears the array accumulators, then streams A/B with diagonal skew into the west/north ports.
//  - Waits for the pipeline to drain, then pulses done; result0..15 then hold C = A x B.

---
 rtl/systolic_feed_if.sv | 13 +
 rtl/systolic_feed_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_if.sv
// Load-port bundle for systolic_feed_ctrl: one A row or B column per accepted beat.
interface systolic_feed_if #(
  parameter int DATA_BIT = 8
);
  logic                  ld_valid;
  logic                  ld_ready;
  logic                  ld_sel;
  logic [1:0]            ld_idx;
  logic [4*DATA_BIT-1:0] ld_data;

  modport master (output ld_valid, ld_sel, ld_idx, ld_data, input ld_ready);
  modport slave  (input ld_valid, ld_sel, ld_idx, ld_data, output ld_ready);
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Job sequencer for a 4x4 output-stationary systolic array: buffers A/B, clears, feeds with skew, drains.
// Optional macro SA_CTRL_JOB_CNT_EN builds a saturating completed-job counter on job_cnt.
module systolic_feed_ctrl #(
  parameter int DATA_BIT     = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  systolic_feed_if.slave      ld,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                arr_rst,
  output logic [DATA_BIT-1:0] west0,
  output logic [DATA_BIT-1:0] west4,
  output logic [DATA_BIT-1:0] west8,
  output logic [DATA_BIT-1:0] west12,
  output logic [DATA_BIT-1:0] north0,
  output logic [DATA_BIT-1:0] north1,
  output logic [DATA_BIT-1:0] north2,
  output logic [DATA_BIT-1:0] north3,
  output logic [15:0]         job_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [3:0] STEP_LAST  = 4'd9;

  state_t              state_r, state_nx_s;
  logic [3:0]          step_r, step_nx_s;
  logic [3:0]          drain_r, drain_nx_s;
  logic [3:0]          diff_s [4];
  logic                busy_r, done_r, clr_r, ready_r;
  logic                ld_acc_s;
  logic [DATA_BIT-1:0] a_buf_r [4][4];
  logic [DATA_BIT-1:0] b_buf_r [4][4];
  logic [DATA_BIT-1:0] west_r [4], west_nx_s [4];
  logic [DATA_BIT-1:0] north_r [4], north_nx_s [4];

  assign ld_acc_s = ld.ld_valid & ready_r;

  // Next-state logic: one CLR cycle, ten feed steps, DRAIN_CYCLES of drain, one DONE cycle.
  always_comb begin
    state_nx_s = state_r;
    step_nx_s  = step_r;
    drain_nx_s = drain_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_CLR;
        else       state_nx_s = ST_IDLE;
      end
      ST_CLR: begin
        state_nx_s = ST_FEED;
        step_nx_s  = 4'd0;
      end
      ST_FEED: begin
        if (step_r == STEP_LAST) begin
          state_nx_s = ST_DRAIN;
          step_nx_s  = 4'd0;
          drain_nx_s = 4'd0;
        end else begin
          step_nx_s = step_r + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) state_nx_s = ST_DONE;
        else                       drain_nx_s = drain_r + 4'd1;
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Skewed feed values for the upcoming cycle: row/column i lags the step by i.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      diff_s[i]     = step_nx_s - 4'(i);
      west_nx_s[i]  = {DATA_BIT{1'b0}};
      north_nx_s[i] = {DATA_BIT{1'b0}};
      if ((state_nx_s == ST_FEED) && (step_nx_s >= 4'(i)) && (diff_s[i] <= 4'd3)) begin
        west_nx_s[i]  = a_buf_r[i][diff_s[i][1:0]];
        north_nx_s[i] = b_buf_r[diff_s[i][1:0]][i];
      end else begin
        west_nx_s[i]  = {DATA_BIT{1'b0}};
        north_nx_s[i] = {DATA_BIT{1'b0}};
      end
    end
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      step_r  <= 4'd0;
      drain_r <= 4'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      clr_r   <= 1'b0;
      ready_r <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        west_r[i]  <= {DATA_BIT{1'b0}};
        north_r[i] <= {DATA_BIT{1'b0}};
      end
    end else begin
      state_r <= state_nx_s;
      step_r  <= step_nx_s;
      drain_r <= drain_nx_s;
      busy_r  <= (state_nx_s == ST_CLR) || (state_nx_s == ST_FEED) || (state_nx_s == ST_DRAIN);
      done_r  <= (state_nx_s == ST_DONE);
      clr_r   <= (state_nx_s == ST_CLR);
      ready_r <= (state_nx_s == ST_IDLE);
      for (int i = 0; i < 4; i++) begin
        west_r[i]  <= west_nx_s[i];
        north_r[i] <= north_nx_s[i];
      end
    end
  end

  // Operand buffers: A stored by row, B stored by column index; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          a_buf_r[r][c] <= {DATA_BIT{1'b0}};
          b_buf_r[r][c] <= {DATA_BIT{1'b0}};
        end
      end
    end else if (ld_acc_s) begin
      for (int k = 0; k < 4; k++) begin
        if (ld.ld_sel) b_buf_r[k][ld.ld_idx] <= ld.ld_data[k*DATA_BIT +: DATA_BIT];
        else           a_buf_r[ld.ld_idx][k] <= ld.ld_data[k*DATA_BIT +: DATA_BIT];
      end
    end
  end

`ifdef SA_CTRL_JOB_CNT_EN
  logic [15:0] job_cnt_r;

  // Completed-job counter, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_cnt_r <= 16'd0;
    end else if ((state_r == ST_DONE) && (job_cnt_r != 16'hFFFF)) begin
      job_cnt_r <= job_cnt_r + 16'd1;
    end
  end

  assign job_cnt = job_cnt_r;
`else
  assign job_cnt = 16'h0000;
`endif

  // The array reset follows the global reset asynchronously as well as the CLR cycle.
  assign arr_rst     = rst | clr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign ld.ld_ready = ready_r;
  assign west0       = west_r[0];
  assign west4       = west_r[1];
  assign west8       = west_r[2];
  assign west12      = west_r[3];
  assign north0      = north_r[0];
  assign north1      = north_r[1];
  assign north2      = north_r[2];
  assign north3      = north_r[3];

endmodule
